room_exit_detector: RTL and testbench
=====================================

// Module: room_exit_detector
// PURPOSE
//   Exit-side counterpart of the room entry detector. Takes the one-cycle "all men in" pulse as a
//   load event and marks all N occupants present. Clears each occupant as his exit sensor fires.
//   Pulses all_men_out when the room is empty again, and flags a timeout if draining stalls.
//   Sits beside the entry detector; all_in is driven directly by that block's all_men_in output.
// PARAMETERS
//   N        4    number of tracked occupants (>=1)
//   TIMEOUT  16   max cycles allowed from first exit to last exit (>=2)
// PORTS
//   clk           in   1              single clock; all state updates on posedge
//   rst_in        in   1              reset, synchronous, active-low (0 = reset at posedge clk)
//   all_in        in   1              load pulse: all N occupants are inside
//   men_out       in   N              bit i high = occupant i seen leaving this cycle
//   all_men_out   out  1              one-cycle pulse: last occupant has left
//   occupancy     out  $clog2(N+1)    number of occupants still marked inside
//   exit_timeout  out  1              level: draining exceeded TIMEOUT cycles
//   busy          out  1              high whenever state != EMPTY
// BEHAVIOUR
//   - Reset (rst_in==0 at posedge) overrides everything, including mid-drain.
//     Reset values: state=EMPTY, present=0, timer=0, all outputs 0.
//   - All outputs are registered. occupancy = popcount(present), updated at the same edge as present.
//   - Internal state: present[N-1:0], timer[$clog2(TIMEOUT)-1:0].
//     FSM states: EMPTY, OCCUPIED, DRAINING, TIMED_OUT.
//   - Precedence each edge: reset > all_in > men_out.
//     When all_in is high, men_out is ignored that cycle.
//   - all_in in ANY state:
//       present <= all ones; timer <= 0; exit_timeout <= 0; state -> OCCUPIED.
//   - EMPTY: men_out ignored; stays EMPTY until all_in.
//   - OCCUPIED/DRAINING/TIMED_OUT, no all_in:
//       present <= present & ~men_out.
//       Exits on bits already clear are ignored (no double counting).
//   - OCCUPIED -> DRAINING when at least one present bit clears but present stays non-zero; timer <= 0.
//   - DRAINING: timer increments by 1 each edge.
//       If the timer is at TIMEOUT-1 and present stays non-zero, go to TIMED_OUT and set exit_timeout <= 1.
//       Net effect: exit_timeout rises TIMEOUT edges after the edge that entered DRAINING.
//   - TIMED_OUT: exit_timeout holds at 1; exits are still tracked; timer is frozen.
//   - Emptying: at the edge where present becomes 0 from any non-EMPTY state:
//       all_men_out <= 1 for exactly one cycle; state -> EMPTY; timer <= 0; exit_timeout <= 0.
//     This also applies to OCCUPIED when all N leave at once (skips DRAINING).
//     Emptying at the same edge as timer expiry: emptying wins and exit_timeout stays 0.
//   - all_men_out is 0 at every other edge. It never asserts at reset or on all_in.
// TESTING
//   1. Reset: hold rst_in=0 three cycles with all_in=1, men_out=4'hF
//      -> all outputs 0, busy=0, occupancy=0.
//   2. Normal drain: all_in pulse; then men_out=0001, 0010, 0100, 1000 on consecutive cycles
//      -> occupancy 4,3,2,1,0; all_men_out high exactly at the edge occupancy hits 0; busy drops at that edge.
//   3. Simultaneous and duplicate exits: all_in, then men_out=0011, then 0011 again, then 1100
//      -> occupancy 4,2,2,0; single all_men_out pulse.
//   4. Timeout (TIMEOUT=16): all_in, men_out=0001 at edge E0, no further exits
//      -> exit_timeout=1 at edge E0+16 and stays; later men_out=1110 -> all_men_out pulse, exit_timeout=0.
//   5. Race: all_in and men_out=4'hF in same cycle -> occupancy=4, no all_men_out.
//      Exit of the last occupant on the expiry edge -> all_men_out=1, exit_timeout=0.
//   6. Reload mid-drain: all_in during DRAINING with occupancy=1 and timer=10
//      -> occupancy=4, timer restarts, no timeout at old deadline.
//      Reset mid-drain -> all outputs 0 next edge.

Source files
------------

// File: rtl/room_exit_detector_if.sv
// Exit-detector signal bundle: load pulse and per-occupant exit strobes in,
// registered status out. The master side drives the inputs, the slave side is the detector.
interface room_exit_detector_if #(
    parameter int N = 4
);
    logic                     all_in;
    logic [N-1:0]             men_out;
    logic                     all_men_out;
    logic [$clog2(N+1)-1:0]   occupancy;
    logic                     exit_timeout;
    logic                     busy;

    modport master (
        output all_in, men_out,
        input  all_men_out, occupancy, exit_timeout, busy
    );

    modport slave (
        input  all_in, men_out,
        output all_men_out, occupancy, exit_timeout, busy
    );
endinterface

// File: rtl/room_exit_detector.sv
// Tracks N occupants from a bulk "all in" load until each exit sensor fires;
// pulses when the room empties and flags a timeout if the drain stalls.
module room_exit_detector #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_in,
    room_exit_detector_if.slave   bus
);
    localparam int OCC_W = $clog2(N+1);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        OCCUPIED  = 2'd1,
        DRAINING  = 2'd2,
        TIMED_OUT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_present;
    logic [N-1:0]       w_present_nxt;
    logic [N-1:0]       w_present_clr;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               r_all_men_out;
    logic               w_all_men_out_nxt;
    logic               r_exit_timeout;
    logic               w_exit_timeout_nxt;
    logic [OCC_W-1:0]   r_occupancy;
    logic               r_busy;

    function automatic logic [OCC_W-1:0] popcount(input logic [N-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        w_state_nxt        = r_state;
        w_present_nxt      = r_present;
        w_timer_nxt        = r_timer;
        w_all_men_out_nxt  = 1'b0;
        w_exit_timeout_nxt = r_exit_timeout;
        w_present_clr      = r_present & ~bus.men_out;

        if (bus.all_in) begin
            // A reload wins over any exits seen in the same cycle.
            w_present_nxt      = '1;
            w_timer_nxt        = '0;
            w_exit_timeout_nxt = 1'b0;
            w_state_nxt        = OCCUPIED;
        end else if (r_state != EMPTY) begin
            w_present_nxt = w_present_clr;
            if (w_present_clr == '0) begin
                // Emptying beats a timer expiry landing on the same edge.
                w_all_men_out_nxt  = 1'b1;
                w_state_nxt        = EMPTY;
                w_timer_nxt        = '0;
                w_exit_timeout_nxt = 1'b0;
            end else if (r_state == OCCUPIED) begin
                if (w_present_clr != r_present) begin
                    w_state_nxt = DRAINING;
                    w_timer_nxt = '0;
                end
            end else if (r_state == DRAINING) begin
                if (r_timer == TMR_W'(TIMEOUT-1)) begin
                    w_state_nxt        = TIMED_OUT;
                    w_exit_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_state        <= EMPTY;
            r_present      <= '0;
            r_timer        <= '0;
            r_all_men_out  <= 1'b0;
            r_exit_timeout <= 1'b0;
            r_occupancy    <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_present      <= w_present_nxt;
            r_timer        <= w_timer_nxt;
            r_all_men_out  <= w_all_men_out_nxt;
            r_exit_timeout <= w_exit_timeout_nxt;
            r_occupancy    <= popcount(w_present_nxt);
            r_busy         <= (w_state_nxt != EMPTY);
        end
    end

    assign bus.all_men_out  = r_all_men_out;
    assign bus.occupancy    = r_occupancy;
    assign bus.exit_timeout = r_exit_timeout;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_room_exit_detector.sv
// Scoreboard bench for room_exit_detector: directed scenarios followed by random traffic,
// checked against an occupant-set model that counts edges since the drain began.
module tb_room_exit_detector;
    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int OCC_W   = $clog2(N+1);

    typedef struct packed {
        logic             amo;
        logic [OCC_W-1:0] occ;
        logic             tmo;
        logic             busy;
    } exp_t;

    logic clk;
    logic rst_in;

    room_exit_detector_if #(.N(N)) ifc ();

    room_exit_detector #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   done   = 0;

    // Reference model state: set of occupants inside, and age of the current drain in edges.
    bit [N-1:0] m_present = '0;
    bit         m_active  = 0;
    bit         m_drain   = 0;
    int         m_age     = 0;
    bit         m_tmo     = 0;
    bit         m_amo     = 0;

    task automatic model_edge(input bit r, input bit a, input bit [N-1:0] m);
        bit [N-1:0] np;
        m_amo = 0;
        if (!r) begin
            m_present = '0; m_active = 0; m_drain = 0; m_age = 0; m_tmo = 0;
        end else if (a) begin
            m_present = '1; m_active = 1; m_drain = 0; m_age = 0; m_tmo = 0;
        end else if (m_active) begin
            np = m_present & ~m;
            if (np == '0) begin
                m_amo = 1; m_active = 0; m_drain = 0; m_age = 0; m_tmo = 0;
            end else if (m_drain) begin
                if (!m_tmo) begin
                    m_age++;
                    if (m_age >= TIMEOUT) m_tmo = 1;
                end
            end else if (np != m_present) begin
                m_drain = 1; m_age = 0;
            end
            m_present = np;
        end
    endtask

    task automatic step(input bit r, input bit a, input bit [N-1:0] m);
        exp_t e;
        @(negedge clk);
        rst_in      = r;
        ifc.all_in  = a;
        ifc.men_out = m;
        model_edge(r, a, m);
        e.amo  = m_amo;
        e.occ  = OCC_W'($countones(m_present));
        e.tmo  = m_tmo;
        e.busy = m_active;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, '0);
    endtask

    // Monitor: every edge produces a registered output vector to check.
    initial begin
        exp_t e;
        exp_t got;
        wait (sb.size() > 0);
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            got.amo  = ifc.all_men_out;
            got.occ  = ifc.occupancy;
            got.tmo  = ifc.exit_timeout;
            got.busy = ifc.busy;
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL sb_empty: output seen at %0t with no expected entry", $time);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_miss++;
                    $display("FAIL vec%0d @%0t: got amo=%b occ=%0d tmo=%b busy=%b, want amo=%b occ=%0d tmo=%b busy=%b",
                             n_vec, $time, got.amo, got.occ, got.tmo, got.busy,
                             e.amo, e.occ, e.tmo, e.busy);
                end
            end
        end
    end

    initial begin
        rst_in      = 1'b0;
        ifc.all_in  = 1'b0;
        ifc.men_out = '0;

        // Reset held with load and exits active
        for (int k = 0; k < 3; k++) step(0, 1, 4'hF);
        idle(2);

        // Sequential drain
        step(1, 1, 4'h0);
        step(1, 0, 4'b0001);
        step(1, 0, 4'b0010);
        step(1, 0, 4'b0100);
        step(1, 0, 4'b1000);
        idle(2);

        // Simultaneous and duplicate exits
        step(1, 1, 4'h0);
        step(1, 0, 4'b0011);
        step(1, 0, 4'b0011);
        step(1, 0, 4'b1100);
        idle(2);

        // Timeout then late drain
        step(1, 1, 4'h0);
        step(1, 0, 4'b0001);
        idle(20);
        step(1, 0, 4'b1110);
        idle(2);

        // Load and full exit together; then last exit on the expiry edge
        step(1, 1, 4'hF);
        step(1, 0, 4'b0111);
        idle(TIMEOUT-1);
        step(1, 0, 4'b1000);
        idle(2);

        // All leave at once from OCCUPIED
        step(1, 1, 4'h0);
        step(1, 0, 4'hF);
        idle(1);

        // Reload mid-drain, then reset mid-drain
        step(1, 1, 4'h0);
        step(1, 0, 4'b0111);
        idle(10);
        step(1, 1, 4'h0);
        step(1, 0, 4'b0001);
        idle(TIMEOUT+2);
        step(1, 1, 4'h0);
        step(1, 0, 4'b0010);
        idle(3);
        step(0, 0, 4'h0);
        idle(2);

        // Random traffic: alternating dense and sparse exit phases
        for (int ph = 0; ph < 12; ph++) begin
            int sparse;
            sparse = (ph % 2) ? 64 : 6;
            for (int k = 0; k < 250; k++) begin
                bit         r;
                bit         a;
                bit [N-1:0] m;
                r = ($urandom_range(0, 199) != 0);
                a = ($urandom_range(0, 29) == 0);
                for (int b = 0; b < N; b++) m[b] = ($urandom_range(0, sparse-1) == 0);
                step(r, a, m);
            end
        end

        idle(1);
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: %0d expected entries left, want 0", sb.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
